// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared types for the MIPS core run controller.
//   run_state_t  : controller FSM states
//   halt_cause_t : reason the controller last entered HALT
//   trace_aw()   : address width of the trace ring for a given depth
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_HALT     = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        HC_NONE  = 2'b00,
        HC_BP    = 2'b01,
        HC_LIMIT = 2'b10
    } halt_cause_t;

    // Depth is a power of two >= 2, so this is never below 1.
    function automatic int trace_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
// Bundles every non-clock signal of the run controller.
//   Host/control : run, step, div, bp_valid, bp_addr, cyc_limit
//   Core side    : pc_in, led_in (from core), cpu_rst, cpu_ce (to core)
//   Status/debug : halted, halt_cause, cycles, trace_count,
//                  trace_idx (in), trace_pc, trace_led
// Modports:
//   master : the host / bench / core side driving the controller
//   slave  : the controller itself
interface cpu_run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 8,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 32,
    parameter int DIV_W       = 8
);
    localparam int AW = trace_aw(TRACE_DEPTH);

    logic              run;
    logic              step;
    logic [DIV_W-1:0]  div;
    logic              bp_valid;
    logic [PC_W-1:0]   bp_addr;
    logic [CNT_W-1:0]  cyc_limit;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] led_in;
    logic              cpu_rst;
    logic              cpu_ce;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycles;
    logic [AW:0]       trace_count;
    logic [AW-1:0]     trace_idx;
    logic [PC_W-1:0]   trace_pc;
    logic [DATA_W-1:0] trace_led;

    modport master (
        output run, step, div, bp_valid, bp_addr, cyc_limit,
        output pc_in, led_in, trace_idx,
        input  cpu_rst, cpu_ce, halted, halt_cause, cycles,
        input  trace_count, trace_pc, trace_led
    );

    modport slave (
        input  run, step, div, bp_valid, bp_addr, cyc_limit,
        input  pc_in, led_in, trace_idx,
        output cpu_rst, cpu_ce, halted, halt_cause, cycles,
        output trace_count, trace_pc, trace_led
    );

endinterface

// File: rtl/run_trace_ring.sv
// run_trace_ring
// Ring buffer of the most recent core PCs (and optionally LED bytes).
// Optional feature macro: RUN_CTRL_LED_TRACE_EN builds the LED column;
// without it rd_led is tied to 0.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : write one entry (one per core clock enable)
//   wr_pc    : PC to store
//   wr_led   : LED byte to store (only kept with the LED column built)
//   rd_idx   : readout index, 0 = most recent entry
//   count    : number of valid entries, saturates at DEPTH
//   rd_pc    : registered PC at rd_idx, 0 when rd_idx >= count
//   rd_led   : registered LED byte at rd_idx, same gating as rd_pc
module run_trace_ring
    import run_ctrl_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int DATA_W = 8,
    localparam int AW    = trace_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PC_W-1:0]   wr_pc,
    input  logic [DATA_W-1:0] wr_led,
    input  logic [AW-1:0]     rd_idx,
    output logic [AW:0]       count,
    output logic [PC_W-1:0]   rd_pc,
    output logic [DATA_W-1:0] rd_led
);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_addr;
    logic            rd_hit;
    logic [PC_W-1:0] pc_mem [DEPTH];

    // Newest entry sits just below the write pointer; the subtraction wraps
    // naturally because DEPTH is a power of two.
    assign rd_addr = wr_ptr - AW'(1) - rd_idx;
    assign rd_hit  = ({1'b0, rd_idx} < count);

    // Pointer and fill level; the oldest entry is overwritten once full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != (AW+1)'(DEPTH)) begin
                count <= count + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: reads are masked by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr] <= wr_pc;
        end
    end

    // Registered read sees the pre-write contents on a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pc <= '0;
        end else begin
            rd_pc <= rd_hit ? pc_mem[rd_addr] : '0;
        end
    end

`ifdef RUN_CTRL_LED_TRACE_EN
    logic [DATA_W-1:0] led_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            led_mem[wr_ptr] <= wr_led;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_led <= '0;
        end else begin
            rd_led <= rd_hit ? led_mem[rd_addr] : '0;
        end
    end
`else
    logic unused_led;
    assign unused_led = ^wr_led;
    assign rd_led     = '0;
`endif

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run controller for the single-cycle MIPS core: sequences core reset,
// gates the core through a divided clock enable, and halts on single-step,
// PC breakpoint or retired-cycle limit. A trace ring keeps recent PCs.
// Optional feature macro: RUN_CTRL_LED_TRACE_EN (LED byte column in trace).
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : cpu_run_ctrl_if.slave carrying run/step/div, breakpoint and
//              cycle-limit controls, core pc_in/led_in, core cpu_rst/cpu_ce,
//              halted/halt_cause/cycles status and the trace readout port.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 8,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 32,
    parameter int DIV_W       = 8,
    parameter int RST_CYC     = 4
) (
    input  logic                clk,
    input  logic                rst,
    cpu_run_ctrl_if.slave       bus
);

    localparam int HW = $clog2(RST_CYC + 1);

    run_state_t       state_q, state_n;
    halt_cause_t      cause_q, cause_n;
    logic [HW-1:0]    hold_q, hold_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [CNT_W-1:0] cycles_q, cycles_n;
    logic             ce;
    logic             tick;
    logic             limit_hit;
    logic             bp_hit;

    assign tick      = (div_q == bus.div);
    assign limit_hit = (bus.cyc_limit != '0) && (cycles_q == bus.cyc_limit);
    assign bp_hit    = bus.bp_valid && (bus.pc_in == bus.bp_addr);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RST_HOLD;
            cause_q  <= HC_NONE;
            hold_q   <= HW'(RST_CYC);
            div_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_n;
            cause_q  <= cause_n;
            hold_q   <= hold_n;
            div_q    <= div_n;
            cycles_q <= cycles_n;
        end
    end

    // Next-state and clock-enable decode. cpu_ce is combinational from the
    // registered state so an asynchronous reset removes it immediately.
    always_comb begin
        state_n  = state_q;
        cause_n  = cause_q;
        hold_n   = hold_q;
        div_n    = div_q;
        cycles_n = cycles_q;
        ce       = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                // Leaving on the edge that would take the count to zero
                // gives exactly RST_CYC clocks of cpu_rst.
                if (hold_q <= HW'(1)) begin
                    hold_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    hold_n = hold_q - HW'(1);
                end
            end

            ST_IDLE: begin
                div_n = '0;
                if (bus.run) begin
                    state_n = ST_RUN;
                end else if (bus.step) begin
                    state_n = ST_STEP;
                end
            end

            ST_RUN: begin
                // Dropping run abandons any partial divide.
                if (!bus.run) begin
                    state_n = ST_IDLE;
                    div_n   = '0;
                end else if (!tick) begin
                    div_n = div_q + DIV_W'(1);
                end else begin
                    div_n = '0;
                    if (limit_hit) begin
                        state_n = ST_HALT;
                        cause_n = HC_LIMIT;
                    end else if (bp_hit) begin
                        state_n = ST_HALT;
                        cause_n = HC_BP;
                    end else begin
                        ce       = 1'b1;
                        cycles_n = cycles_q + CNT_W'(1);
                    end
                end
            end

            ST_STEP: begin
                // A step ignores the breakpoint so it can move past it.
                state_n = ST_HALT;
                if (limit_hit) begin
                    cause_n = HC_LIMIT;
                end else begin
                    cause_n  = HC_NONE;
                    ce       = 1'b1;
                    cycles_n = cycles_q + CNT_W'(1);
                end
            end

            ST_HALT: begin
                if (bus.step) begin
                    state_n = ST_STEP;
                end else if (!bus.run) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.cpu_rst    = (state_q == ST_RST_HOLD);
    assign bus.cpu_ce     = ce;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.halt_cause = cause_q;
    assign bus.cycles     = cycles_q;

    run_trace_ring #(
        .DEPTH  (TRACE_DEPTH),
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_trace (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (ce),
        .wr_pc  (bus.pc_in),
        .wr_led (bus.led_in),
        .rd_idx (bus.trace_idx),
        .count  (bus.trace_count),
        .rd_pc  (bus.trace_pc),
        .rd_led (bus.trace_led)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. A tiny core model advances pc_in by 4
// (and led_in = pc[7:0]^A5) after every cpu_ce. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_cpu_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int PC_W        = 32;
    localparam int DATA_W      = 8;
    localparam int TRACE_DEPTH = 16;
    localparam int CNT_W       = 32;
    localparam int DIV_W       = 8;
    localparam int RST_CYC     = 4;

`ifdef RUN_CTRL_LED_TRACE_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ce_count = 0;

    cpu_run_ctrl_if #(
        .PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(TRACE_DEPTH),
        .CNT_W(CNT_W), .DIV_W(DIV_W)
    ) bus ();

    cpu_run_ctrl #(
        .PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(TRACE_DEPTH),
        .CNT_W(CNT_W), .DIV_W(DIV_W), .RST_CYC(RST_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic set_pc(input logic [31:0] v);
        bus.pc_in  = v;
        bus.led_in = v[7:0] ^ 8'hA5;
    endtask

    // One clock: remember whether the core was enabled, advance the core
    // model just after the edge, return at the next falling edge.
    task automatic clk_cycle();
        logic ce_now;
        ce_now = bus.cpu_ce;
        @(posedge clk);
        #1;
        if (ce_now) begin
            ce_count++;
            set_pc(bus.pc_in + 32'd4);
        end
        @(negedge clk);
    endtask

    task automatic drive_idle_inputs();
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.div       = '0;
        bus.bp_valid  = 1'b0;
        bus.bp_addr   = '0;
        bus.cyc_limit = '0;
        bus.trace_idx = '0;
        set_pc(32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (RST_CYC) clk_cycle();
        ce_count = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle_inputs();
        #1;
        total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("[TB] FAIL rst_cpu_rst actual=%0h required=1", bus.cpu_rst); end
        total++; if (bus.cpu_ce !== 1'b0) begin bad++; $display("[TB] FAIL rst_cpu_ce actual=%0h required=0", bus.cpu_ce); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL rst_halted actual=%0h required=0", bus.halted); end
        total++; if (bus.halt_cause !== 2'b00) begin bad++; $display("[TB] FAIL rst_cause actual=%0h required=0", bus.halt_cause); end
        total++; if (bus.cycles !== 32'd0) begin bad++; $display("[TB] FAIL rst_cycles actual=%0h required=0", bus.cycles); end
        total++; if (bus.trace_count !== 5'd0) begin bad++; $display("[TB] FAIL rst_trace_count actual=%0h required=0", bus.trace_count); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < RST_CYC; i++) begin
            total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("[TB] FAIL hold_cpu_rst clk=%0d actual=%0h required=1", i, bus.cpu_rst); end
            clk_cycle();
        end
        total++; if (bus.cpu_rst !== 1'b0) begin bad++; $display("[TB] FAIL hold_release actual=%0h required=0", bus.cpu_rst); end
        total++; if (bus.cycles !== 32'd0) begin bad++; $display("[TB] FAIL idle_cycles actual=%0h required=0", bus.cycles); end
        total++; if (bus.cpu_ce !== 1'b0) begin bad++; $display("[TB] FAIL idle_cpu_ce actual=%0h required=0", bus.cpu_ce); end
    endtask

    task automatic test_run_div();
        do_reset();
        bus.div = 8'd2;
        bus.run = 1'b1;
        clk_cycle();
        for (int i = 0; i < 30; i++) begin
            total++; if (bus.cpu_ce !== ((i % 3) == 2)) begin bad++; $display("[TB] FAIL div_ce sample=%0d actual=%0h required=%0h", i, bus.cpu_ce, ((i % 3) == 2)); end
            clk_cycle();
        end
        total++; if (bus.cycles !== 32'd10) begin bad++; $display("[TB] FAIL div_cycles actual=%0d required=10", bus.cycles); end
        bus.run = 1'b0;
        clk_cycle();
        total++; if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL div_stop_halted actual=%0h required=0", bus.halted); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        set_pc(32'h0040_0000);
        bus.bp_valid = 1'b1;
        bus.bp_addr  = 32'h0040_0010;
        bus.run      = 1'b1;
        for (int i = 0; i < 20 && !bus.halted; i++) clk_cycle();
        total++; if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL bp_halted actual=%0h required=1", bus.halted); end
        total++; if (bus.halt_cause !== 2'b01) begin bad++; $display("[TB] FAIL bp_cause actual=%0h required=1", bus.halt_cause); end
        total++; if (bus.cycles !== 32'd4) begin bad++; $display("[TB] FAIL bp_cycles actual=%0d required=4", bus.cycles); end
        total++; if (ce_count != 4) begin bad++; $display("[TB] FAIL bp_ce_count actual=%0d required=4", ce_count); end
        bus.step = 1'b1;
        clk_cycle();
        bus.step = 1'b0;
        total++; if (bus.cpu_ce !== 1'b1) begin bad++; $display("[TB] FAIL step_past_bp_ce actual=%0h required=1", bus.cpu_ce); end
        clk_cycle();
        total++; if (bus.cycles !== 32'd5) begin bad++; $display("[TB] FAIL step_cycles actual=%0d required=5", bus.cycles); end
        total++; if (bus.halt_cause !== 2'b00) begin bad++; $display("[TB] FAIL step_cause actual=%0h required=0", bus.halt_cause); end
        clk_cycle();
        total++; if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL run_high_stays_halted actual=%0h required=1", bus.halted); end
        bus.run = 1'b0;
        clk_cycle();
    endtask

    task automatic test_cycle_limit();
        do_reset();
        bus.cyc_limit = 32'd7;
        bus.run       = 1'b1;
        for (int i = 0; i < 40 && !bus.halted; i++) clk_cycle();
        total++; if (ce_count != 7) begin bad++; $display("[TB] FAIL lim_ce_count actual=%0d required=7", ce_count); end
        total++; if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL lim_halted actual=%0h required=1", bus.halted); end
        total++; if (bus.halt_cause !== 2'b10) begin bad++; $display("[TB] FAIL lim_cause actual=%0h required=2", bus.halt_cause); end
        bus.run = 1'b0;
        clk_cycle();
        total++; if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL lim_idle_halted actual=%0h required=0", bus.halted); end
        total++; if (bus.halt_cause !== 2'b10) begin bad++; $display("[TB] FAIL lim_cause_held actual=%0h required=2", bus.halt_cause); end
        // A step at the limit must not enable the core.
        bus.step = 1'b1;
        clk_cycle();
        bus.step = 1'b0;
        total++; if (bus.cpu_ce !== 1'b0) begin bad++; $display("[TB] FAIL lim_step_ce actual=%0h required=0", bus.cpu_ce); end
        clk_cycle();
        total++; if (bus.halt_cause !== 2'b10) begin bad++; $display("[TB] FAIL lim_step_cause actual=%0h required=2", bus.halt_cause); end
        total++; if (bus.cycles !== 32'd7) begin bad++; $display("[TB] FAIL lim_step_cycles actual=%0d required=7", bus.cycles); end
    endtask

    task automatic test_trace_wrap();
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 60 && ce_count < 20; i++) clk_cycle();
        bus.run = 1'b0;
        total++; if (ce_count != 20) begin bad++; $display("[TB] FAIL trace_ce_count actual=%0d required=20", ce_count); end
        clk_cycle();
        total++; if (bus.trace_count !== 5'd16) begin bad++; $display("[TB] FAIL trace_count actual=%0d required=16", bus.trace_count); end
        bus.trace_idx = 4'd0;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h4C) begin bad++; $display("[TB] FAIL trace_idx0_pc actual=%0h required=4c", bus.trace_pc); end
        total++; if (bus.trace_led !== (LED_EN ? 8'hE9 : 8'h00)) begin bad++; $display("[TB] FAIL trace_idx0_led actual=%0h required=%0h", bus.trace_led, (LED_EN ? 8'hE9 : 8'h00)); end
        bus.trace_idx = 4'd15;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h10) begin bad++; $display("[TB] FAIL trace_idx15_pc actual=%0h required=10", bus.trace_pc); end
        total++; if (bus.trace_led !== (LED_EN ? 8'hB5 : 8'h00)) begin bad++; $display("[TB] FAIL trace_idx15_led actual=%0h required=%0h", bus.trace_led, (LED_EN ? 8'hB5 : 8'h00)); end
        bus.trace_idx = 4'd5;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h38) begin bad++; $display("[TB] FAIL trace_idx5_pc actual=%0h required=38", bus.trace_pc); end
        total++; if (bus.trace_led !== (LED_EN ? 8'h9D : 8'h00)) begin bad++; $display("[TB] FAIL trace_idx5_led actual=%0h required=%0h", bus.trace_led, (LED_EN ? 8'h9D : 8'h00)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_pc(32'h100);
        bus.bp_valid = 1'b1;
        bus.bp_addr  = 32'h100;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1;
            clk_cycle();
            bus.step = 1'b0;
            total++; if (bus.cpu_ce !== 1'b1) begin bad++; $display("[TB] FAIL b2b_step_ce k=%0d actual=%0h required=1", k, bus.cpu_ce); end
            clk_cycle();
            total++; if (bus.halted !== 1'b1) begin bad++; $display("[TB] FAIL b2b_halted k=%0d actual=%0h required=1", k, bus.halted); end
        end
        total++; if (bus.cycles !== 32'd3) begin bad++; $display("[TB] FAIL b2b_cycles actual=%0d required=3", bus.cycles); end
        total++; if (bus.trace_count !== 5'd3) begin bad++; $display("[TB] FAIL b2b_trace_count actual=%0d required=3", bus.trace_count); end
        bus.trace_idx = 4'd0;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h108) begin bad++; $display("[TB] FAIL b2b_idx0_pc actual=%0h required=108", bus.trace_pc); end
        total++; if (bus.trace_led !== (LED_EN ? 8'hAD : 8'h00)) begin bad++; $display("[TB] FAIL b2b_idx0_led actual=%0h required=%0h", bus.trace_led, (LED_EN ? 8'hAD : 8'h00)); end
        bus.trace_idx = 4'd2;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h100) begin bad++; $display("[TB] FAIL b2b_idx2_pc actual=%0h required=100", bus.trace_pc); end
        bus.trace_idx = 4'd3;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h0) begin bad++; $display("[TB] FAIL b2b_idx3_pc actual=%0h required=0", bus.trace_pc); end
    endtask

    task automatic test_run_step_priority();
        do_reset();
        bus.run  = 1'b1;
        bus.step = 1'b1;
        clk_cycle();
        bus.step = 1'b0;
        clk_cycle();
        clk_cycle();
        total++; if (ce_count != 2) begin bad++; $display("[TB] FAIL prio_ce_count actual=%0d required=2", ce_count); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL prio_halted actual=%0h required=0", bus.halted); end
        bus.run = 1'b0;
        clk_cycle();
    endtask

    task automatic test_rst_mid_run();
        do_reset();
        bus.run = 1'b1;
        repeat (6) clk_cycle();
        total++; if (bus.cycles !== 32'd5) begin bad++; $display("[TB] FAIL mid_pre_cycles actual=%0d required=5", bus.cycles); end
        total++; if (bus.cpu_ce !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_ce actual=%0h required=1", bus.cpu_ce); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.cpu_ce !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ce actual=%0h required=0", bus.cpu_ce); end
        total++; if (bus.cycles !== 32'd0) begin bad++; $display("[TB] FAIL mid_rst_cycles actual=%0d required=0", bus.cycles); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_halted actual=%0h required=0", bus.halted); end
        total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_cpu_rst actual=%0h required=1", bus.cpu_rst); end
        total++; if (bus.trace_count !== 5'd0) begin bad++; $display("[TB] FAIL mid_rst_trace_count actual=%0d required=0", bus.trace_count); end
        bus.run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (RST_CYC) clk_cycle();
        bus.trace_idx = 4'd0;
        clk_cycle();
        total++; if (bus.trace_pc !== 32'h0) begin bad++; $display("[TB] FAIL mid_trace_pc actual=%0h required=0", bus.trace_pc); end
        total++; if (bus.trace_led !== 8'h00) begin bad++; $display("[TB] FAIL mid_trace_led actual=%0h required=0", bus.trace_led); end
    endtask

    initial begin
        test_reset();
        test_run_div();
        test_breakpoint();
        test_cycle_limit();
        test_trace_wrap();
        test_back_to_back();
        test_run_step_priority();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for the single-cycle MIPS core, the parametrised successor to the free-running simulation clock fixture. It sequences core reset and gates the core through a clock enable, with a programmable divide ratio. It supports run, single-step, PC breakpoint and cycle-limit halts. It also keeps a ring-buffer trace of the most recent program counters so a bench or debug port can see how the core reached its halt.

## Interface
- PC_W, 32, program counter width (matches core `cur`)
- DATA_W, 8, LED/debug byte width (matches core `led`)
- TRACE_DEPTH, 16, trace entries; power of two, ≥2
- CNT_W, 32, retired-cycle counter width
- DIV_W, 8, clock-enable divider width
- RST_CYC, 4, cycles core reset is held after `rst`; ≥1
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; request free-running execution
- step  in  1  one-cycle pulse; request exactly one core cycle
- div  in  DIV_W  `cpu_ce` asserted once every div+1 clk cycles
- bp_valid  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint PC
- cyc_limit  in  CNT_W  halt after this many retired cycles; 0 = unlimited
- pc_in  in  PC_W  core current PC
- led_in  in  DATA_W  core LED byte
- cpu_rst  out  1  core reset, active-high
- cpu_ce  out  1  core clock enable, one-clk pulse per core cycle
- halted  out  1  controller in HALT
- halt_cause  out  2  00 none/step, 01 breakpoint, 10 cycle limit
- cycles  out  CNT_W  retired core cycles since reset
- trace_count  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturates at TRACE_DEPTH
- trace_idx  in  $clog2(TRACE_DEPTH)  readout index; 0 = most recent
- trace_pc  out  PC_W  registered trace PC at `trace_idx`
- trace_led  out  DATA_W  registered trace LED byte (see Configuration)

## Operation
- States: RST_HOLD, IDLE, RUN, STEP, HALT.
- `rst` asserted: RST_HOLD, hold counter=RST_CYC, cpu_rst=1, cpu_ce=0, halted=0, halt_cause=00, cycles=0, trace_count=0, write pointer=0, divider=0, trace_pc/trace_led=0.
- RST_HOLD: decrement each clk; at 0 → IDLE and cpu_rst=0. Inputs ignored.
- IDLE: run=1 → RUN (divider cleared); else step=1 → STEP.
- RUN: divider counts 0..div. On the tick cycle (divider==div), check in priority order:
  - 1. cyc_limit≠0 and cycles==cyc_limit → HALT, cause 10, no CE.
  - 2. bp_valid and pc_in==bp_addr → HALT, cause 01, no CE.
  - 3. Otherwise cpu_ce=1, cycles+1, trace write.
  - run=0 on any cycle → IDLE, in-progress divide discarded.
- STEP: one cpu_ce next clk regardless of breakpoint. Cycle limit still honoured, giving HALT cause 10. Then → HALT, cause 00.
- HALT: halted=1. step=1 → STEP, which steps past a breakpoint. run=0 and step=0 → IDLE, with halt_cause kept until the next halt. run held high stays halted.
- Trace write on every cpu_ce: store pc_in (and led_in) at write pointer. The pointer wraps modulo TRACE_DEPTH and the oldest entry is overwritten. trace_count saturates.
- Readout: entry = (wrptr−1−trace_idx) mod TRACE_DEPTH. If trace_idx ≥ trace_count, the output is 0.
- cycles wraps at 2^CNT_W; with cyc_limit=0 it never halts.

## Timing
- cpu_ce: one-clk pulse. With div=0 it is asserted every clk in RUN. Minimum spacing in RUN is div+1 clks.
- First CE occurs div+1 clks after entering RUN.
- pc_in, led_in and bp compare are sampled on the CE cycle, i.e. the PC executing at that core edge.
- trace_pc/trace_led: 1-clk registered latency from trace_idx. A write and a read in the same clk return the pre-write contents.
- run and step both high in IDLE: run wins.
- `rst` mid-RUN: outputs reset immediately (asynchronous); cpu_ce drops the same instant.

## Configuration
- RUN_CTRL_LED_TRACE_EN defined: trace entries are PC_W+DATA_W wide and trace_led returns the captured led_in.
- Undefined: the LED column is not built and trace_led is tied 0. PC trace behaviour is unchanged.

## Structure
- Package `run_ctrl_pkg`: state enum, halt_cause codes (HC_NONE, HC_BP, HC_LIMIT).
- Sub-module `run_trace_ring`: ring buffer with write pointer, saturating count and registered indexed read. The controller FSM, divider and counters stay in the top.

## Test plan
- Reset, RST_CYC=4: cpu_rst high for exactly 4 clks after rst falls, then IDLE with cycles=0.
- run=1, div=2, free PCs: cpu_ce every 3rd clk; after 10 pulses cycles=10.
- bp_addr=0x0040_0010, PCs stepping by 4 from 0x0040_0000: halt on the 5th tick with cause 01, cycles=4. A step pulse then gives one CE, cycles=5, cause 00.
- cyc_limit=7, div=0: exactly 7 CEs, then HALT cause 10. Lowering run goes to IDLE with the cause held.
- TRACE_DEPTH=16, 20 CEs with PC=k·4: trace_count=16, idx0=0x4C, idx15=0x10.
- rst asserted mid-RUN: cpu_ce and halted go 0 and cycles=0 without a clock edge. Trace reads return 0 afterwards.
